// File: rtl/clz_normalizer.sv
// Count-leading-zeros/ones and normalize unit: a fixed 5-step binary search
// (K = 16, 8, 4, 2, 1) with a start/valid handshake and 5-cycle latency.
module clz_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  output logic        busy,
  output logic        valid,
  output logic [5:0]  count,
  output logic [31:0] norm
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] w_q, w_d;
  logic [31:0] s_q, s_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  stage_q, stage_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] norm_q, norm_d;

  logic [5:0]  step_amt_s;
  logic        top_zero_s;
  logic [31:0] w_step_s;
  logic [31:0] s_step_s;
  logic [5:0]  cnt_step_s;

  // Shift amount and top-K test for the current search stage.
  always_comb begin
    step_amt_s = 6'd1;
    case (stage_q)
      3'd0:    step_amt_s = 6'd16;
      3'd1:    step_amt_s = 6'd8;
      3'd2:    step_amt_s = 6'd4;
      3'd3:    step_amt_s = 6'd2;
      default: step_amt_s = 6'd1;
    endcase
    top_zero_s = ((w_q >> (6'd32 - step_amt_s)) == 32'd0);
    if (top_zero_s) begin
      w_step_s   = w_q << step_amt_s;
      s_step_s   = s_q << step_amt_s;
      cnt_step_s = cnt_q + step_amt_s;
    end else begin
      w_step_s   = w_q;
      s_step_s   = s_q;
      cnt_step_s = cnt_q;
    end
  end

  // Next-state logic: accept, search step, and the folded final adjust.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    count_d = count_q;
    norm_d  = norm_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_d     = op ? ~a : a;
          s_d     = a;
          cnt_d   = 6'd0;
          stage_d = 3'd0;
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        w_d     = w_step_s;
        s_d     = s_step_s;
        cnt_d   = cnt_step_s;
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'd4) begin
          // A still-clear bit 31 means no significant bit existed at all.
          if (!w_step_s[31]) begin
            cnt_d = cnt_step_s + 6'd1;
            s_d   = 32'd0;
          end else begin
            cnt_d = cnt_step_s;
            s_d   = s_step_s;
          end
          count_d = cnt_d;
          norm_d  = s_d;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= 32'd0;
      s_q     <= 32'd0;
      cnt_q   <= 6'd0;
      stage_q <= 3'd0;
      count_q <= 6'd0;
      norm_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      count_q <= count_d;
      norm_q  <= norm_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign valid = (state_q == ST_DONE);
  assign count = count_q;
  assign norm  = norm_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Directed bench for clz_normalizer: a queue holds hand-computed results and a
// monitor compares them whenever valid rises, plus handshake timing checks.
module tb_clz_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'd0;
  logic        busy;
  logic        valid;
  logic [5:0]  count;
  logic [31:0] norm;

  clz_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .busy  (busy),
    .valid (valid),
    .count (count),
    .norm  (norm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  c;
    logic [31:0] n;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk_res(input string name, input logic [5:0] ac, input logic [31:0] an,
                         input logic [5:0] ec, input logic [31:0] en);
    n_vec++;
    if (ac !== ec || an !== en) begin
      n_err++;
      $display("FAIL %s: got count=%0d norm=%h, expected count=%0d norm=%h", name, ac, an, ec, en);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Monitor: compare on each rising valid, and check the held result while valid stays high.
  exp_t last_exp;
  logic valid_prev = 1'b0;
  initial begin
    last_exp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (valid && !valid_prev) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got count=%0d norm=%h with nothing pending", count, norm);
        end else begin
          last_exp = sb_q.pop_front();
          chk_res("result", count, norm, last_exp.c, last_exp.n);
        end
      end else if (valid && valid_prev) begin
        chk_res("held_result", count, norm, last_exp.c, last_exp.n);
      end
      valid_prev = valid;
    end
  end

  task automatic push_exp(input logic [5:0] c, input logic [31:0] n);
    exp_t e;
    e.c = c;
    e.n = n;
    sb_q.push_back(e);
  endtask

  // One full operation with busy/valid checks at every edge from E0 to E5.
  task automatic issue(input logic o, input logic [31:0] v, input logic [5:0] c, input logic [31:0] n);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = v;
    push_exp(c, n);
    @(posedge clk);
    #1;
    chk_bit("busy_after_e0", busy, 1'b1);
    chk_bit("valid_after_e0", valid, 1'b0);
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    a     = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk_bit("busy_mid_run", busy, 1'b1);
    end
    @(posedge clk);
    #1;
    chk_bit("busy_after_e5", busy, 1'b0);
    chk_bit("valid_after_e5", valid, 1'b1);
  endtask

  initial begin
    #2;
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_valid", valid, 1'b0);
    chk_res("reset_outputs", count, norm, 6'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 32'h0000_0000, 6'd32, 32'h0000_0000);
    issue(1'b0, 32'h0001_0000, 6'd15, 32'h8000_0000);
    issue(1'b0, 32'h8000_0000, 6'd0,  32'h8000_0000);
    issue(1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000);
    issue(1'b0, 32'h0000_F000, 6'd16, 32'hF000_0000);
    issue(1'b1, 32'hFFFF_0F00, 6'd16, 32'h0F00_0000);
    issue(1'b1, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000);
    issue(1'b1, 32'h7FFF_FFFF, 6'd0,  32'h7FFF_FFFF);
    issue(1'b1, 32'h8000_0000, 6'd1,  32'h0000_0000);

    // start pulsed at E2 with a different operand must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h0001_0000;
    push_exp(6'd15, 32'h8000_0000);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("ignore_valid_at_e5", valid, 1'b1);
    chk_bit("ignore_busy_at_e5", busy, 1'b0);
    @(posedge clk);
    #1;
    chk_bit("ignore_no_restart", busy, 1'b0);

    // start held across DONE: back-to-back operations
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h0000_0003;
    push_exp(6'd30, 32'hC000_0000);
    @(posedge clk);
    #1;
    chk_bit("b2b_valid_drop_first", valid, 1'b0);
    @(negedge clk);
    op = 1'b1; a = 32'hFFFF_FFFE;
    push_exp(6'd31, 32'h0000_0000);
    repeat (5) @(posedge clk);
    #1;
    chk_bit("b2b_first_valid", valid, 1'b1);
    @(posedge clk);
    #1;
    chk_bit("b2b_valid_drop_second", valid, 1'b0);
    chk_bit("b2b_busy_second", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_bit("b2b_second_valid", valid, 1'b1);

    // reset between E2 and E3 aborts with no result
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_valid", valid, 1'b0);
    chk_res("abort_outputs", count, norm, 6'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h0000_0100, 6'd23, 32'h8000_0000);

    for (int t = 0; t < 20; t++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d results still pending, expected 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
